// File: rtl/aes_block_assembler.sv
// rtl/aes_block_assembler.sv - packs FIFO bytes MSB-first into PKCS#7-padded plaintext blocks
//
// Sits between the data FIFO and the AES core. Pops bytes into a BYTES-wide
// block. On flush, it pads a partial final block with PKCS#7 bytes. Each
// finished block is offered to the core with a valid/ready handshake.
//
// Ports:
//   clk, n_rst     clock and synchronous active-low reset
//   fifo_empty     FIFO empty flag; fifo_r_data is the head byte when not empty
//   fifo_r_enable  pop strobe; a pop happens on every edge where it is high
//   flush          one-cycle end-of-message pulse (latched until consumed)
//   block_ready    AES core accepts the block on this edge when block_valid=1
//   block_valid    block_data holds a complete block
//   block_data     assembled block; the first byte popped is in the top byte
//   block_padded   the presented block ends in PKCS#7 padding
//   byte_cnt       bytes loaded into the block in progress
module aes_block_assembler #(
  parameter int BYTES = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               fifo_empty,
  input  logic [7:0]         fifo_r_data,
  output logic               fifo_r_enable,
  input  logic               flush,
  input  logic               block_ready,
  output logic               block_valid,
  output logic [BYTES*8-1:0] block_data,
  output logic               block_padded,
  output logic [CNT_W-1:0]   byte_cnt
);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PAD,
    ST_HOLD
  } state_e;

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BYTES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTES*8-1:0] data_q, data_d;
  logic               padded_q, padded_d;
  logic               flush_pend_q, flush_pend_d;
  logic [7:0]         pad_val_q, pad_val_d;
  logic               wr_en;
  logic [7:0]         wr_byte;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    padded_d      = padded_q;
    pad_val_d     = pad_val_q;
    flush_pend_d  = flush_pend_q | flush;
    fifo_r_enable = 1'b0;
    wr_en         = 1'b0;
    wr_byte       = fifo_r_data;

    unique case (state_q)
      ST_FILL: begin
        // Gated by n_rst so nothing is popped while reset is held.
        fifo_r_enable = !fifo_empty && n_rst;
        if (!fifo_empty) begin
          // Data wins over a pending flush: the flush waits for an empty FIFO.
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_SLOT) begin
            state_d  = ST_HOLD;
            padded_d = 1'b0;
          end
        end else if (flush_pend_q) begin
          // Consume the pending flush; a new pulse this very cycle stays latched.
          flush_pend_d = flush;
          if (cnt_q != '0) begin
            state_d   = ST_PAD;
            pad_val_d = 8'(BYTES) - 8'(cnt_q);
          end
        end
      end

      ST_PAD: begin
        wr_en   = 1'b1;
        wr_byte = pad_val_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_SLOT) begin
          state_d  = ST_HOLD;
          padded_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (block_ready) begin
          state_d  = ST_FILL;
          cnt_d    = '0;
          padded_d = 1'b0;
        end
      end

      default: state_d = ST_FILL;
    endcase

    // Slot 0 is the most significant byte of the block.
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          data_d[(BYTES-1-i)*8 +: 8] = wr_byte;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= ST_FILL;
      cnt_q        <= '0;
      data_q       <= '0;
      padded_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      pad_val_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      padded_q     <= padded_d;
      flush_pend_q <= flush_pend_d;
      pad_val_q    <= pad_val_d;
    end
  end

  assign block_valid  = (state_q == ST_HOLD);
  assign block_data   = data_q;
  assign block_padded = padded_q;
  assign byte_cnt     = cnt_q;

endmodule

// File: tb/tb_aes_block_assembler.sv
// tb/tb_aes_block_assembler.sv - self-checking bench for aes_block_assembler
module tb_aes_block_assembler;
  localparam int BYTES = 16;
  localparam int CNT_W = 5;
  localparam int W     = BYTES * 8;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [7:0]       fifo_r_data = 8'h00;
  logic             flush = 1'b0;
  logic             block_ready = 1'b0;
  logic             fifo_r_enable;
  logic             block_valid;
  logic [W-1:0]     block_data;
  logic             block_padded;
  logic [CNT_W-1:0] byte_cnt;

  always #5 clk = ~clk;

  aes_block_assembler #(.BYTES(BYTES), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .fifo_empty   (fifo_empty),
    .fifo_r_data  (fifo_r_data),
    .fifo_r_enable(fifo_r_enable),
    .flush        (flush),
    .block_ready  (block_ready),
    .block_valid  (block_valid),
    .block_data   (block_data),
    .block_padded (block_padded),
    .byte_cnt     (byte_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]   fifo_q[$];
  logic [W-1:0] rx_data[$];
  logic         rx_pad[$];
  int           pops = 0;
  int           valid_cycles = 0;
  bit           rand_ready = 0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_pad = 1'b0;

  function automatic void check(string name, logic [W-1:0] got, logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endfunction

  function automatic void drive_fifo();
    fifo_empty  = (fifo_q.size() == 0);
    fifo_r_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endfunction

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    drive_fifo();
  endtask

  // One clock: observe at negedge, apply FIFO/transfer effects after the edge.
  task automatic cycle();
    logic pop;
    logic xfer;
    @(negedge clk);
    pop  = fifo_r_enable;
    xfer = block_valid && block_ready && n_rst;
    if (pop) check("pop_nonempty", W'(fifo_q.size() != 0), W'(1));
    if (block_valid && n_rst) begin
      valid_cycles++;
      check("no_pop_in_hold", W'(fifo_r_enable), W'(0));
      if (prev_hold) begin
        check("hold_data_stable", block_data, prev_data);
        check("hold_pad_stable", W'(block_padded), W'(prev_pad));
      end
      if (xfer) begin
        rx_data.push_back(block_data);
        rx_pad.push_back(block_padded);
      end
    end
    prev_hold = block_valid && !xfer && n_rst;
    prev_data = block_data;
    prev_pad  = block_padded;
    @(posedge clk);
    #1;
    if (pop && n_rst && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    flush = 1'b0;
    if (rand_ready) block_ready = ($urandom_range(0, 2) != 0);
    drive_fifo();
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (fifo_q.size() != 0 && n < 500) begin
      cycle();
      n++;
    end
    if (fifo_q.size() != 0) check("fifo_drain_timeout", W'(fifo_q.size()), W'(0));
  endtask

  typedef struct {
    int           n;
    logic [7:0]   start;
    logic [7:0]   step;
    bit           do_flush;
    int           exp_nblk;
    logic [W-1:0] exp_data;
    bit           exp_pad;
  } vec_t;

  vec_t         vecs[6];
  int           rx0, p0, vc0, wcnt, len, k, target;
  logic [7:0]   b;
  logic [7:0]   msg[$];
  logic [W-1:0] exp_blk[$];
  logic         exp_pad[$];
  logic [W-1:0] blk;

  initial begin
    vecs[0] = '{16, 8'h00, 8'h01, 1'b0, 1, 128'h000102030405060708090A0B0C0D0E0F, 1'b0};
    vecs[1] = '{3,  8'hAA, 8'h11, 1'b1, 1, 128'hAABBCC0D0D0D0D0D0D0D0D0D0D0D0D0D, 1'b1};
    vecs[2] = '{1,  8'h55, 8'h00, 1'b1, 1, 128'h550F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 1'b1};
    vecs[3] = '{15, 8'h10, 8'h01, 1'b1, 1, 128'h101112131415161718191A1B1C1D1E01, 1'b1};
    vecs[4] = '{0,  8'h00, 8'h00, 1'b1, 0, '0, 1'b0};
    vecs[5] = '{2,  8'hFE, 8'h01, 1'b1, 1, 128'hFEFF0E0E0E0E0E0E0E0E0E0E0E0E0E0E, 1'b1};

    // Reset with a non-empty FIFO.
    n_rst = 1'b0;
    push_byte(8'hEE);
    push_byte(8'hEF);
    cycle();
    cycle();
    check("rst_fifo_r_enable", W'(fifo_r_enable), W'(0));
    check("rst_block_valid", W'(block_valid), W'(0));
    check("rst_byte_cnt", W'(byte_cnt), W'(0));
    check("rst_block_data", block_data, '0);
    check("rst_block_padded", W'(block_padded), W'(0));
    n_rst = 1'b1;
    block_ready = 1'b1;
    wait_empty();
    flush = 1'b1;
    repeat (25) cycle();
    check("post_rst_nblk", W'(rx_data.size()), W'(1));
    if (rx_data.size() >= 1) begin
      check("post_rst_data", rx_data[0], 128'hEEEF0E0E0E0E0E0E0E0E0E0E0E0E0E0E);
      check("post_rst_pad", W'(rx_pad[0]), W'(1));
    end

    // Table vectors.
    for (int v = 0; v < 6; v++) begin
      rx0 = rx_data.size();
      p0  = pops;
      vc0 = valid_cycles;
      b   = vecs[v].start;
      for (int i = 0; i < vecs[v].n; i++) begin
        push_byte(b);
        b = b + vecs[v].step;
      end
      if (vecs[v].do_flush) flush = 1'b1;
      cycle();
      wait_empty();
      repeat (25) cycle();
      check("vec_nblk", W'(rx_data.size() - rx0), W'(vecs[v].exp_nblk));
      check("vec_pops", W'(pops - p0), W'(vecs[v].n));
      check("vec_valid_cycles", W'(valid_cycles - vc0), W'(vecs[v].exp_nblk));
      if (vecs[v].exp_nblk > 0 && rx_data.size() > rx0) begin
        check("vec_data", rx_data[rx_data.size()-1], vecs[v].exp_data);
        check("vec_pad", W'(rx_pad[rx_pad.size()-1]), W'(vecs[v].exp_pad));
      end
    end

    // Partial block latency: 3 bytes then flush -> 13 PAD cycles.
    push_byte(8'hAA);
    push_byte(8'hBB);
    push_byte(8'hCC);
    wait_empty();
    cycle();
    flush = 1'b1;
    cycle();
    check("lat_cnt_before_pad", W'(byte_cnt), W'(3));
    wcnt = 0;
    while (!block_valid && wcnt < 50) begin
      wcnt++;
      cycle();
    end
    check("lat_pad_cycles", W'(wcnt), W'(14));
    check("lat_padded", W'(block_padded), W'(1));
    check("lat_data", block_data, 128'hAABBCC0D0D0D0D0D0D0D0D0D0D0D0D0D);
    repeat (3) cycle();

    // Backpressure: 20 bytes queued, ready low for 10 cycles in HOLD.
    block_ready = 1'b0;
    rx0 = rx_data.size();
    for (int i = 0; i < 20; i++) push_byte(8'h40 + 8'(i));
    wcnt = 0;
    while (!block_valid && wcnt < 100) begin
      wcnt++;
      cycle();
    end
    check("bp_valid", W'(block_valid), W'(1));
    check("bp_data", block_data, 128'h404142434445464748494A4B4C4D4E4F);
    repeat (10) cycle();
    check("bp_fifo_left", W'(fifo_q.size()), W'(4));
    block_ready = 1'b1;
    wait_empty();
    check("bp_cnt_after", W'(byte_cnt), W'(4));
    flush = 1'b1;
    repeat (25) cycle();
    check("bp_nblk", W'(rx_data.size() - rx0), W'(2));
    if (rx_data.size() >= rx0 + 2) begin
      check("bp_blk0", rx_data[rx0], 128'h404142434445464748494A4B4C4D4E4F);
      check("bp_blk1", rx_data[rx0+1], 128'h505152530C0C0C0C0C0C0C0C0C0C0C0C);
      check("bp_blk1_pad", W'(rx_pad[rx0+1]), W'(1));
    end

    // Flush with byte_cnt=10 and 5 bytes still in the FIFO.
    rx0 = rx_data.size();
    for (int i = 0; i < 10; i++) push_byte(8'h60 + 8'(i));
    wait_empty();
    check("f10_cnt", W'(byte_cnt), W'(10));
    for (int i = 10; i < 15; i++) push_byte(8'h60 + 8'(i));
    flush = 1'b1;
    cycle();
    wait_empty();
    repeat (10) cycle();
    check("f10_nblk", W'(rx_data.size() - rx0), W'(1));
    if (rx_data.size() > rx0) begin
      check("f10_data", rx_data[rx0], 128'h606162636465666768696A6B6C6D6E01);
      check("f10_pad", W'(rx_pad[rx0]), W'(1));
    end

    // Reset in the middle of PAD at byte_cnt=9.
    rx0 = rx_data.size();
    for (int i = 0; i < 3; i++) push_byte(8'h70 + 8'(i));
    wait_empty();
    flush = 1'b1;
    cycle();
    wcnt = 0;
    while (byte_cnt != 5'd9 && wcnt < 30) begin
      wcnt++;
      cycle();
    end
    check("mr_reached_9", W'(byte_cnt), W'(9));
    n_rst = 1'b0;
    cycle();
    check("mr_cnt", W'(byte_cnt), W'(0));
    check("mr_valid", W'(block_valid), W'(0));
    n_rst = 1'b1;
    repeat (30) cycle();
    check("mr_no_block", W'(rx_data.size() - rx0), W'(0));
    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
    wait_empty();
    repeat (5) cycle();
    check("mr_nblk", W'(rx_data.size() - rx0), W'(1));
    if (rx_data.size() > rx0) begin
      check("mr_data", rx_data[rx0], 128'h808182838485868788898A8B8C8D8E8F);
      check("mr_pad", W'(rx_pad[rx0]), W'(0));
    end

    // Random messages against a chunk-and-pad reference model.
    rand_ready = 1;
    for (int m = 0; m < 25; m++) begin
      msg.delete();
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
      exp_blk.delete();
      exp_pad.delete();
      for (int off = 0; off < len; off += BYTES) begin
        k = (len - off < BYTES) ? (len - off) : BYTES;
        blk = '0;
        for (int j = 0; j < BYTES; j++) begin
          blk = {blk[W-9:0], (j < k) ? msg[off+j] : 8'(BYTES - k)};
        end
        exp_blk.push_back(blk);
        exp_pad.push_back(k < BYTES);
      end
      rx0 = rx_data.size();
      target = rx0 + exp_blk.size();
      for (int idx = 0; idx < len; ) begin
        k = $urandom_range(1, 6);
        for (int j = 0; j < k && idx < len; j++) begin
          push_byte(msg[idx]);
          idx++;
        end
        repeat ($urandom_range(0, 3)) cycle();
      end
      flush = 1'b1;
      cycle();
      wcnt = 0;
      while ((rx_data.size() < target || fifo_q.size() != 0) && wcnt < 3000) begin
        wcnt++;
        cycle();
      end
      repeat (3) cycle();
      check("rnd_nblk", W'(rx_data.size() - rx0), W'(exp_blk.size()));
      for (int i = 0; i < exp_blk.size() && rx0 + i < rx_data.size(); i++) begin
        check("rnd_data", rx_data[rx0+i], exp_blk[i]);
        check("rnd_pad", W'(rx_pad[rx0+i]), W'(exp_pad[i]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
